// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, default latencies and FSM state type for the mul/div unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MFHI  = 3'd6;
    localparam logic [2:0] MD_MFLO  = 3'd7;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {S_IDLE, S_RUN} md_state_e;

endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc: combinational signed/unsigned 32x32 multiply and divide producing {hi,lo}.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] res,
    output logic        div0
);
    logic        sgn;
    logic [63:0] xa, xb;
    logic [31:0] ua, ub, uq, ur;
    always_comb begin
        sgn  = (op == MD_MULT) || (op == MD_DIV);
        xa   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        xb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        ua   = (sgn && a[31]) ? -a : a;
        ub   = (sgn && b[31]) ? -b : b;
        div0 = (b == 32'd0);
        uq   = div0 ? 32'd0 : ua / ub;
        ur   = div0 ? 32'd0 : ua % ub;
        // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows dividend.
        res  = op[1] ? {(sgn && a[31]) ? -ur : ur, (sgn && (a[31] ^ b[31])) ? -uq : uq}
                     : xa * xb;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mul/div with HI/LO registers; results commit when the busy countdown ends.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] result
);
    md_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_t_q, hi_t_d, lo_t_q, lo_t_d;
    logic [63:0] calc_res;
    logic        div0, accept, arith;

    muldiv_calc u_calc (.a(a), .b(b), .op(op), .res(calc_res), .div0(div0));

    assign busy   = (state_q == S_RUN);
    assign result = (op == MD_MFHI) ? hi_q : lo_q;
    assign accept = start && !flush && !busy;
    assign arith  = !op[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_t_d  = hi_t_q;
        lo_t_d  = lo_t_q;
        if (busy) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                hi_d    = hi_t_q;
                lo_d    = lo_t_q;
                state_d = S_IDLE;
            end
        end else if (accept && arith) begin
            // A zero divisor commits the current HI/LO back, leaving them unchanged.
            hi_t_d  = (op[1] && div0) ? hi_q : calc_res[63:32];
            lo_t_d  = (op[1] && div0) ? lo_q : calc_res[31:0];
            cnt_d   = op[1] ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
            state_d = S_RUN;
        end else if (accept) begin
            hi_d = (op == MD_MTHI) ? a : hi_q;
            lo_d = (op == MD_MTLO) ? a : lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_t_q  <= '0;
            lo_t_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_t_q  <= hi_t_d;
            lo_t_q  <= lo_t_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand sequences for busy-start and async reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = MD_MFLO;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic        fl;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t v[12];

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(output logic [31:0] hi, output logic [31:0] lo);
        op = MD_MFHI;
        #1 hi = result;
        op = MD_MFLO;
        #1 lo = result;
    endtask

    task automatic run(input logic [2:0] o, input logic fl, input logic [31:0] x,
                       input logic [31:0] y, output int n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] hi, lo;
        v[0]  = '{MD_MULT,  1'b0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1]  = '{MD_MULTU, 1'b0, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        v[2]  = '{MD_DIV,   1'b0, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[3]  = '{MD_DIVU,  1'b0, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        v[4]  = '{MD_DIVU,  1'b0, 32'd7,        32'd0,        10, 32'h00000001, 32'h00000003};
        v[5]  = '{MD_DIV,   1'b0, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        v[6]  = '{MD_MULT,  1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        v[7]  = '{MD_DIV,   1'b0, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        v[8]  = '{MD_MTHI,  1'b1, 32'h1234,     32'd0,        0,  32'h00000001, 32'hFFFFFFFD};
        v[9]  = '{MD_MTHI,  1'b0, 32'h1234,     32'd0,        0,  32'h00001234, 32'hFFFFFFFD};
        v[10] = '{MD_MTLO,  1'b0, 32'h5678,     32'd0,        0,  32'h00001234, 32'h00005678};
        v[11] = '{MD_MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};

        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        rd(hi, lo);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(v[i].op, v[i].fl, v[i].a, v[i].b, n);
            check($sformatf("v%0d busy cycles", i), 32'(n), 32'(v[i].cyc));
            rd(hi, lo);
            check($sformatf("v%0d hi", i), hi, v[i].hi);
            check($sformatf("v%0d lo", i), lo, v[i].lo);
        end

        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd2; b = 32'd3;
        n = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (busy) n++;
            start = 1'b1; op = k ? MD_DIV : MD_MTHI; a = 32'hDEAD; b = 32'd1;
        end
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy-start cycles", 32'(n), 32'd5);
        rd(hi, lo);
        check("busy-start hi", hi, 32'd0);
        check("busy-start lo", lo, 32'd6);
        @(negedge clk);
        check("busy-start no requeue", {31'd0, busy}, 32'd0);

        // async reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("div running", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        rd(hi, lo);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post reset busy", {31'd0, busy}, 32'd0);
        rd(hi, lo);
        check("post reset hi", hi, 32'd0);
        check("post reset lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers. It lives in the execute stage of the five-stage MIPS pipeline. It is the producer of the `mfhi`/`mflo` value that the forwarding logic later routes from M as the "mulOut" source. It also exposes `busy`, which the hazard/stall logic uses to hold `mult`/`div`/`mf*`/`mt*` in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of `mult`/`multu`. Must be ≥ 1.
- `DIV_CYCLES`, default 10: busy duration of `div`/`divu`. Must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: E-stage instruction is a mul/div/mt/mf class op (qualified by `op`).
- `op` in 3: operation code. 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`, 4 `mthi`, 5 `mtlo`, 6 `mfhi`, 7 `mflo`.
- `a` in 32: forwarded rs value from E.
- `b` in 32: forwarded rt value from E.
- `flush` in 1: exception/interrupt taken at M. Suppresses any new start/mt this cycle.
- `busy` out 1: operation in flight.
- `result` out 32: `hi` when `op`==6, otherwise `lo`. Combinational.

## Operation
- Accept condition: `start && !flush && !busy`.
- Accepted `op` 0–3:
  - Compute the 64-bit product or the quotient/remainder from `a`/`b` at the accept edge, into temp regs `hi_t`/`lo_t`.
  - Load `cnt` with the op's cycle count and set `busy`.
- Accepted `op` 4/5: write `a` into HI/LO at the edge. No busy.
- `op` 6/7: pure read. No state change.
- `mult`: signed 32×32→64. `multu`: unsigned. {HI,LO} = product.
- `div`/`divu`: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divisor 0: HI/LO keep their prior values. `busy` still runs the full DIV_CYCLES.
- Each edge while busy: `cnt` decrements. When `cnt`==1, the edge commits `hi_t`/`lo_t` to HI/LO and clears `busy`.
- `start` while busy: ignored entirely; no state change. Hazard logic must prevent this; the bench checks it.
- `flush` never cancels an op already in flight. It only blocks the accept in its own cycle.
- Reset mid-operation: HI, LO, `hi_t`, `lo_t`, `cnt` all go to 0 and `busy` to 0 immediately. The pending result is lost.

## Timing
- Reset values: `busy`=0, `result`=0 (HI=LO=0).
- `busy` rises on the accept edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). It falls on the same edge that writes HI/LO.
- Hazard logic stalls D when `busy || start` on a mul/div/mf/mt op. The first `mf*` read is therefore in the cycle after `busy` falls, and it sees the new value.
- `mthi`/`mtlo`: the new value is visible on `result` in the cycle after the write edge.
- `result` has zero latency from `op` and from the HI/LO registers.

## Structure
- Shared pipeline package holds:
  - op encodings `MD_MULT`..`MD_MFLO` (3 bits);
  - the default cycle constants.
- The decode/interpreter already emits `muldiv`/`mt`/`mf` class flags; the E stage maps them to `op`.
- One natural sub-module: `muldiv_calc`.
  - Combinational; takes `a`, `b`, `op`; returns a 64-bit `{hi,lo}` plus a `div0` flag.
  - Isolates the signed/unsigned arithmetic from the counter/commit FSM.
- FSM: IDLE (`busy`=0) → RUN (`cnt` counting) → IDLE on `cnt`==1.

## Test plan
- `mult` a=0xFFFFFFFE (−2), b=3 → `busy` high 5 cycles. Then `mflo`=0xFFFFFFFA and `mfhi`=0xFFFFFFFF.
- `multu` same operands → HI=0x00000002, LO=0xFFFFFFFA.
- `div` a=−7, b=2 → after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- `divu` a=7, b=2 → LO=3, HI=1.
- `divu` b=0 → HI/LO unchanged, `busy` still high 10 cycles.
- `mthi` 0x1234 with `flush`=1 → HI unchanged. Repeat with `flush`=0 → `mfhi`=0x1234 next cycle.
- `start` during busy → ignored.
- Async `reset` in cycle 3 of a `div` → `busy`=0 and HI=LO=0 immediately, without waiting for a clock edge.
